// File: rtl/jcsa_pkg.sv
// Shared constants and state encoding for the sequential carry-skip subtractor.
package jcsa_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/jcsa_slice4.sv
// Combinational 4-bit carry-skip slice: ripple carry with a propagate-AND bypass.
module jcsa_slice4
    import jcsa_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    always_comb begin
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
    end

    assign sum = p ^ c[SLICE_W-1:0];

    // When every bit propagates the carry-in is forwarded directly.
    assign cout = (&p) ? cin : c[SLICE_W];

endmodule

// File: rtl/jcsa_seq_subtractor.sv
// Sequential WIDTH-bit subtractor Y = A - B - borrowin, one 4-bit slice per clock.
// Optional signed overflow output enabled by defining JCSUB_OVERFLOW_EN.
module jcsa_seq_subtractor
    import jcsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             borrowin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             borrowout
`ifdef JCSUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int N  = WIDTH / SLICE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   nb_reg;
    logic               carry;
    int                 idx;
    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               c_out;
    logic               last;

    assign idx   = SLICE_W * int'(cnt);
    assign a_nib = a_reg[idx +: SLICE_W];
    assign b_nib = nb_reg[idx +: SLICE_W];
    assign last  = (cnt == CW'(N - 1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    jcsa_slice4 u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .sum  (s_nib),
        .cout (c_out)
    );

    // Subtraction runs as A + ~B with carry = ~borrow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            nb_reg    <= '0;
            carry     <= 1'b0;
            Y         <= '0;
            borrowout <= 1'b0;
`ifdef JCSUB_OVERFLOW_EN
            overflow  <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg  <= A;
                        nb_reg <= ~B;
                        carry  <= ~borrowin;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    Y[idx +: SLICE_W] <= s_nib;
                    carry             <= c_out;
                    if (last) begin
                        borrowout <= ~c_out;
`ifdef JCSUB_OVERFLOW_EN
                        overflow  <= (a_reg[WIDTH-1] == nb_reg[WIDTH-1]) &&
                                     (s_nib[SLICE_W-1] != a_reg[WIDTH-1]);
`endif
                        cnt       <= '0;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
